// File: rtl/out_wrapper.sv
// -----------------------------------------------------------------------------
// out_wrapper
//   Two-entry output FIFO between the floating-point multiplier and an
//   external consumer. Products are pushed on a valid/ready handshake and
//   popped on a valid/ack handshake. A wrapping counter reports how many
//   words have been delivered since reset.
//
// Optional feature (macro OUT_WRAPPER_FLAGS_EN):
//   Adds the outFlags output = {isNaN, isInf, isZero}. The flags are
//   classified from resBus at push time, stored with each entry and presented
//   together with outBus. Without the macro the port and its storage are absent.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   resBus    : IEEE-754 single-precision product from the multiplier
//   resValid  : resBus qualifier
//   resReady  : wrapper can accept a product this cycle (registered state only)
//   outBus    : oldest buffered product, 0 while outValid=0
//   outValid  : outBus qualifier
//   outAck    : consumer takes outBus this cycle
//   sentCount : words delivered since reset, wraps at 2^CNT_W
//   outFlags  : {isNaN, isInf, isZero} of outBus (OUT_WRAPPER_FLAGS_EN only)
// -----------------------------------------------------------------------------
module out_wrapper #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      resBus,
    input  logic             resValid,
    output logic             resReady,
    output logic [31:0]      outBus,
    output logic             outValid,
    input  logic             outAck,
    output logic [CNT_W-1:0] sentCount
`ifdef OUT_WRAPPER_FLAGS_EN
    ,
    output logic [2:0]       outFlags
`endif
);

    // Occupancy encoding
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [31:0]      r_head;
    logic [31:0]      r_tail;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Handshake flags depend only on registered occupancy, so resReady never
    // combinationally depends on outAck.
    assign resReady  = (r_state != S_FULL);
    assign outValid  = (r_state != S_EMPTY);
    assign outBus    = outValid ? r_head : 32'd0;
    assign sentCount = r_count;

    assign w_push = resValid & resReady;
    assign w_pop  = outValid & outAck;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_head  <= 32'd0;
            r_tail  <= 32'd0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_count <= r_count + CNT_ONE;
            end
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        r_head  <= resBus;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        // Old head leaves while the new word takes its place.
                        r_head <= resBus;
                    end else if (w_push) begin
                        r_tail  <= resBus;
                        r_state <= S_FULL;
                    end else if (w_pop) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    // No push is possible here because resReady is low.
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_state <= S_ONE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty FIFO.
                    r_state <= S_EMPTY;
                end
            endcase
        end
    end

`ifdef OUT_WRAPPER_FLAGS_EN
    logic [7:0]  w_exp;
    logic [22:0] w_man;
    logic [2:0]  w_in_flags;
    logic [2:0]  r_head_flags;
    logic [2:0]  r_tail_flags;

    // Sign bit is ignored for the classification.
    assign w_exp = resBus[30:23];
    assign w_man = resBus[22:0];
    assign w_in_flags = {
        (w_exp == 8'hFF) && (w_man != 23'd0),
        (w_exp == 8'hFF) && (w_man == 23'd0),
        (w_exp == 8'h00) && (w_man == 23'd0)
    };

    assign outFlags = outValid ? r_head_flags : 3'b000;

    // Flag storage follows exactly the same moves as the data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_flags <= 3'b000;
            r_tail_flags <= 3'b000;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        r_head_flags <= w_in_flags;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        r_head_flags <= w_in_flags;
                    end else if (w_push) begin
                        r_tail_flags <= w_in_flags;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        r_head_flags <= r_tail_flags;
                    end
                end
                default: begin
                    r_head_flags <= r_head_flags;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_out_wrapper.sv
// -----------------------------------------------------------------------------
// tb_out_wrapper
//   Directed scenarios followed by randomized traffic. The reference model is
//   a plain queue of words plus a delivered-word counter modulo 16 (CNT_W=4).
// -----------------------------------------------------------------------------
module tb_out_wrapper;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   resBus;
    logic          resValid;
    logic          resReady;
    logic [31:0]   outBus;
    logic          outValid;
    logic          outAck;
    logic [CW-1:0] sentCount;
`ifdef OUT_WRAPPER_FLAGS_EN
    logic [2:0]    outFlags;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] q[$];
    int          cnt = 0;

    always #5 clk = ~clk;

    out_wrapper #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .resBus    (resBus),
        .resValid  (resValid),
        .resReady  (resReady),
        .outBus    (outBus),
        .outValid  (outValid),
        .outAck    (outAck),
        .sentCount (sentCount)
`ifdef OUT_WRAPPER_FLAGS_EN
        ,
        .outFlags  (outFlags)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

`ifdef OUT_WRAPPER_FLAGS_EN
    function automatic logic [2:0] flags_of(input logic [31:0] w);
        int e;
        int m;
        e = int'(w[30:23]);
        m = int'(w[22:0]);
        return {e == 255 && m != 0, e == 255 && m == 0, e == 0 && m == 0};
    endfunction
`endif

    // Compare every output against the queue model.
    task automatic check_outputs();
        logic [31:0] exp_bus;
        exp_bus = (q.size() > 0) ? q[0] : 32'd0;
        chk("resReady",  32'(resReady),  32'(q.size() < 2));
        chk("outValid",  32'(outValid),  32'(q.size() > 0));
        chk("outBus",    outBus,         exp_bus);
        chk("sentCount", 32'(sentCount), 32'(cnt));
`ifdef OUT_WRAPPER_FLAGS_EN
        chk("outFlags",  32'(outFlags),  32'((q.size() > 0) ? flags_of(q[0]) : 3'b000));
`endif
    endtask

    // One clock cycle: drive inputs, advance the model across the edge, check.
    task automatic step(input logic r, input logic v, input logic [31:0] d, input logic a);
        bit do_push;
        bit do_pop;
        rst      = r;
        resValid = v;
        resBus   = d;
        outAck   = a;
        do_push  = v && (q.size() < 2);
        do_pop   = a && (q.size() > 0);
        @(posedge clk);
        if (r) begin
            q.delete();
            cnt = 0;
        end else begin
            if (do_pop) begin
                void'(q.pop_front());
                cnt = (cnt + 1) % (1 << CW);
            end
            if (do_push) q.push_back(d);
        end
        #1;
        check_outputs();
    endtask

    initial begin
        logic [31:0] specials [6];
        logic [31:0] d;
        specials[0] = 32'h7FC00000;
        specials[1] = 32'hFF800000;
        specials[2] = 32'h80000000;
        specials[3] = 32'h00000000;
        specials[4] = 32'h7F800001;
        specials[5] = 32'h3F800000;
        rst = 1'b1; resValid = 1'b0; resBus = 32'd0; outAck = 1'b0;

        // Reset state
        step(1, 0, 32'd0, 1);
        chk("reset_valid", 32'(outValid), 32'd0);
        chk("reset_ready", 32'(resReady), 32'd1);
        chk("reset_bus",   outBus,        32'd0);

        // Single word, held while not acknowledged
        step(0, 1, 32'h40490FDB, 0);
        chk("single_bus", outBus, 32'h40490FDB);
        repeat (5) step(0, 0, 32'd0, 0);
        chk("single_hold", outBus, 32'h40490FDB);
        step(0, 0, 32'd0, 1);
        chk("single_sent",  32'(sentCount), 32'd1);
        chk("single_empty", 32'(outValid),  32'd0);

        // Fill and backpressure
        step(1, 0, 32'd0, 0);
        step(0, 1, 32'h3F800000, 0);
        step(0, 1, 32'h40000000, 0);
        chk("fill_ready", 32'(resReady), 32'd0);
        step(0, 1, 32'hC0400000, 0);
        chk("fill_first", outBus, 32'h3F800000);
        step(0, 0, 32'd0, 1);
        chk("fill_second", outBus, 32'h40000000);
        step(0, 0, 32'd0, 1);
        chk("fill_drained", 32'(outValid), 32'd0);
        chk("fill_sent",    32'(sentCount), 32'd2);

        // Simultaneous push and pop with one entry
        step(1, 0, 32'd0, 0);
        step(0, 1, 32'h11111111, 0);
        step(0, 1, 32'h22222222, 1);
        chk("pp_bus",   outBus,         32'h22222222);
        chk("pp_sent",  32'(sentCount), 32'd1);
        chk("pp_ready", 32'(resReady),  32'd1);

        // Reset overrides a pop while full
        step(1, 0, 32'd0, 0);
        step(0, 1, 32'hAAAA0001, 0);
        step(0, 1, 32'hAAAA0002, 1);
        step(0, 1, 32'hAAAA0003, 0);
        step(1, 0, 32'd0, 1);
        chk("rstmid_valid", 32'(outValid),  32'd0);
        chk("rstmid_bus",   outBus,         32'd0);
        chk("rstmid_sent",  32'(sentCount), 32'd0);
        chk("rstmid_ready", 32'(resReady),  32'd1);

        // Counter wrap: 17 deliveries with a 4-bit counter
        step(1, 0, 32'd0, 0);
        for (int i = 0; i < 17; i++) step(0, 1, 32'h1000 + 32'(i), 1'(i != 0));
        step(0, 0, 32'd0, 1);
        chk("wrap_sent", 32'(sentCount), 32'd1);

`ifdef OUT_WRAPPER_FLAGS_EN
        // Flag classification on delivery
        step(1, 0, 32'd0, 0);
        step(0, 1, 32'h7FC00000, 0);
        chk("flag_nan", 32'(outFlags), 32'd4);
        step(0, 1, 32'hFF800000, 1);
        chk("flag_inf", 32'(outFlags), 32'd2);
        step(0, 1, 32'h80000000, 1);
        chk("flag_zero", 32'(outFlags), 32'd1);
        step(0, 0, 32'd0, 1);
        chk("flag_idle", 32'(outFlags), 32'd0);
`endif

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) d = specials[$urandom_range(5)];
            else d = $urandom;
            step(1'($urandom_range(49) == 0), 1'($urandom_range(1)), d, 1'($urandom_range(2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/out_wrapper.md
OUT_WRAPPER -- requirements
Module: out_wrapper

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the delivered-word counter sentCount.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1, SHALL be the synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 Port resBus, input, 32, SHALL carry the IEEE-754 single-precision product from the multiplier.
REQ-005 Port resValid, input, 1, SHALL qualify resBus.
REQ-006 Port resReady, output, 1, SHALL indicate that the wrapper can accept a product this cycle.
REQ-007 Port outBus, output, 32, SHALL present the oldest buffered product to the external consumer.
REQ-008 Port outValid, output, 1, SHALL qualify outBus.
REQ-009 Port outAck, input, 1, SHALL indicate that the consumer takes outBus this cycle.
REQ-010 Port sentCount, output, CNT_W, SHALL count words delivered since reset.

Function
REQ-011 Storage SHALL be a 2-entry FIFO: head register H, tail register T, occupancy state EMPTY/ONE/FULL.
REQ-012 A push SHALL occur on a clk edge where resValid=1 and resReady=1.
REQ-013 resReady SHALL be 1 in EMPTY and ONE and 0 in FULL; it SHALL be a function of registered state only.
REQ-014 A pop SHALL occur on a clk edge where outValid=1 and outAck=1.
REQ-015 outValid SHALL be 1 in ONE and FULL and 0 in EMPTY.
REQ-016 outBus SHALL equal H when outValid=1 and SHALL equal 32'd0 when outValid=0.
REQ-017 Latency: a word pushed at edge N SHALL be visible on outBus with outValid=1 in the cycle after edge N if the FIFO was EMPTY.
REQ-018 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE with H=new word; FULL+pop->ONE with H<=T; all other cases SHALL hold the current state.
REQ-019 resValid while resReady=0 SHALL be ignored; no data SHALL be overwritten or lost.
REQ-020 outAck while outValid=0 SHALL have no effect.
REQ-021 Words SHALL leave in strict arrival order; H and T SHALL hold their value while outAck=0.
REQ-022 sentCount SHALL increment by 1 on every pop and wrap from 2^CNT_W-1 to 0.

Reset
REQ-023 On rst=1 the state SHALL become EMPTY, and H, T and sentCount SHALL become 0.
REQ-024 Reset SHALL override a simultaneous push or pop; buffered words SHALL be discarded.
REQ-025 In the cycle after reset, the outputs SHALL be outValid=0, outBus=0 and resReady=1.

Configuration
REQ-026 Macro OUT_WRAPPER_FLAGS_EN, when defined, SHALL add output port outFlags, width 3, ordered {isNaN, isInf, isZero}.
REQ-027 When OUT_WRAPPER_FLAGS_EN is defined, the flags SHALL be computed from resBus at push, stored alongside each entry, and presented aligned with outBus.
REQ-028 isNaN SHALL be exp=8'hFF with mantissa!=0; isInf SHALL be exp=8'hFF with mantissa=0; isZero SHALL be exp=0 with mantissa=0; the sign SHALL be ignored.
REQ-029 When OUT_WRAPPER_FLAGS_EN is defined, outFlags SHALL be 3'b000 whenever outValid=0 and after reset.
REQ-030 Without OUT_WRAPPER_FLAGS_EN, the outFlags port and its storage SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-031 Single word: push 32'h40490FDB with outAck=0 -> next cycle outValid=1, outBus=32'h40490FDB; hold 5 cycles unchanged; outAck=1 for one cycle -> outValid=0, sentCount=1.
REQ-032 Fill and backpressure: push 32'h3F800000 then 32'h40000000 with outAck=0 -> resReady=0; a third push of 32'hC0400000 is ignored; two acks deliver 3F800000 then 40000000, then outValid=0.
REQ-033 Simultaneous push and pop in ONE: H=32'h11111111; push 32'h22222222 with outAck=1 -> state stays ONE, outBus=32'h22222222, sentCount+1.
REQ-034 Reset mid-operation: in FULL, assert rst together with outAck=1 -> next cycle outValid=0, outBus=0, sentCount=0, resReady=1.
REQ-035 Counter wrap: with CNT_W=4, deliver 17 words -> sentCount=1.
REQ-036 With OUT_WRAPPER_FLAGS_EN defined, push 32'h7FC00000, 32'hFF800000, 32'h80000000 -> outFlags equals 3'b100, 3'b010, 3'b001 respectively on delivery.
